// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register chain with valid, stall, flush and forwarding taps.
// Optional macro PIPE_STAGE_RD0_SQUASH_EN: clear RegWrite at capture when rd_addr_i is x0.
module pipe_stage_reg #(
    parameter int unsigned STAGES   = 1,
    parameter int unsigned NUM_DATA = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CTRL_W   = 2,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned WE_BIT   = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0]   data_i,
    input  logic [RD_W-1:0]              rd_addr_i,
    output logic                         valid_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0]   data_o,
    output logic [RD_W-1:0]              rd_addr_o,
    output logic [STAGES-1:0]            fwd_we_o,
    output logic [STAGES*RD_W-1:0]       fwd_rd_o
);

    localparam int unsigned DW = NUM_DATA * DATA_W;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [STAGES-1:0][DW-1:0]     data_q, data_d;
    logic [STAGES-1:0][RD_W-1:0]   rd_q, rd_d;
    logic [CTRL_W-1:0]             ctrl_in;

    // Invalid instructions enter with ctrl cleared so a bubble can never write back.
    always_comb begin
        ctrl_in = valid_i ? ctrl_i : '0;
`ifdef PIPE_STAGE_RD0_SQUASH_EN
        if (rd_addr_i == '0) begin
            ctrl_in[WE_BIT] = 1'b0;
        end
`endif
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        rd_d    = rd_q;
        if (flush_i) begin
            valid_d = '0;
            ctrl_d  = '0;
            data_d  = '0;
            rd_d    = '0;
        end else if (!stall_i) begin
            valid_d[0] = valid_i;
            ctrl_d[0]  = ctrl_in;
            data_d[0]  = data_i;
            rd_d[0]    = rd_addr_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                ctrl_d[s]  = ctrl_q[s-1];
                data_d[s]  = data_q[s-1];
                rd_d[s]    = rd_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        fwd_we_o = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            fwd_we_o[s] = valid_q[s] & ctrl_q[s][WE_BIT];
        end
    end

    assign fwd_rd_o  = rd_q;
    assign valid_o   = valid_q[STAGES-1];
    assign ctrl_o    = ctrl_q[STAGES-1];
    assign data_o    = data_q[STAGES-1];
    assign rd_addr_o = rd_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a 2-stage and a 3-stage instance share one input stream.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid;
    logic [1:0]  ctrl;
    logic [63:0] data;
    logic [4:0]  rd;

    logic        v2_o, v3_o;
    logic [1:0]  c2_o, c3_o;
    logic [63:0] d2_o, d3_o;
    logic [4:0]  r2_o, r3_o;
    logic [1:0]  we2_o;
    logic [2:0]  we3_o;
    logic [9:0]  fr2_o;
    logic [14:0] fr3_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .ctrl_i(ctrl), .data_i(data), .rd_addr_i(rd), .valid_o(v2_o), .ctrl_o(c2_o),
        .data_o(d2_o), .rd_addr_o(r2_o), .fwd_we_o(we2_o), .fwd_rd_o(fr2_o)
    );

    pipe_stage_reg #(.STAGES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .ctrl_i(ctrl), .data_i(data), .rd_addr_i(rd), .valid_o(v3_o), .ctrl_o(c3_o),
        .data_o(d3_o), .rd_addr_o(r3_o), .fwd_we_o(we3_o), .fwd_rd_o(fr3_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [63:0] d,
                         input logic [4:0] r);
        valid = v;
        ctrl  = c;
        data  = d;
        rd    = r;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 64'h0, 5'd0);
        step();
        check("rst_v2", 64'(v2_o), 64'd0);
        check("rst_d2", d2_o, 64'd0);
        check("rst_fwd3", {49'd0, fr3_o}, 64'd0);
        rst = 1'b0;

        // Latency on the 2-stage instance
        drive(1'b1, 2'b11, 64'hDEADBEEF_00000004, 5'd7);
        step();
        check("lat_we_e0", 64'(we2_o), 64'd1);
        check("lat_v_e0", 64'(v2_o), 64'd0);
        check("lat_frd_e0", 64'(fr2_o), 64'd7);
        drive(1'b0, 2'b11, 64'h55, 5'd9);
        step();
        check("lat_v_e1", 64'(v2_o), 64'd1);
        check("lat_c_e1", 64'(c2_o), 64'd3);
        check("lat_d_e1", d2_o, 64'hDEADBEEF_00000004);
        check("lat_rd_e1", 64'(r2_o), 64'd7);
        check("inv_we", 64'(we2_o), 64'd2);
        check("lat3_v_e1", 64'(v3_o), 64'd0);
        step();
        check("lat3_v_e2", 64'(v3_o), 64'd1);
        check("lat3_d_e2", d3_o, 64'hDEADBEEF_00000004);
        check("inv_ctrl2", 64'(c2_o), 64'd0);

        // Stall: A then B loaded, three stalled cycles with changing inputs
        drive(1'b1, 2'b01, 64'd1, 5'd3);
        step();
        drive(1'b1, 2'b01, 64'd2, 5'd4);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 64'(100 + i), 5'(20 + i));
            step();
            check("stall_rd", 64'(r2_o), 64'd3);
            check("stall_frd", 64'(fr2_o), 64'd100);
            check("stall_we", 64'(we2_o), 64'd3);
        end
        stall = 1'b0;
        drive(1'b1, 2'b00, 64'd6, 5'd6);
        step();
        check("unst_rd", 64'(r2_o), 64'd4);
        check("unst_d", d2_o, 64'd2);
        check("unst_frd", 64'(fr2_o), 64'd134);
        check("unst_we", 64'(we2_o), 64'd2);
        drive(1'b0, 2'b00, 64'd0, 5'd0);
        step();
        check("unst2_rd", 64'(r2_o), 64'd6);
        check("unst2_v", 64'(v2_o), 64'd1);

        // Flush wins over stall
        drive(1'b1, 2'b01, 64'd11, 5'd5);
        step();
        drive(1'b1, 2'b11, 64'd12, 5'd8);
        step();
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("fl_v", 64'(v2_o), 64'd0);
        check("fl_c", 64'(c2_o), 64'd0);
        check("fl_d", d2_o, 64'd0);
        check("fl_we", 64'(we2_o), 64'd0);
        check("fl_frd3", {49'd0, fr3_o}, 64'd0);

        // Asynchronous reset mid-stream on the 3-stage instance
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b01, 64'(i), 5'(i));
            step();
        end
        check("rs_pre_v3", 64'(v3_o), 64'd1);
        check("rs_pre_rd3", 64'(r3_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rs_v3", 64'(v3_o), 64'd0);
        check("rs_rd3", 64'(r3_o), 64'd0);
        check("rs_we3", 64'(we3_o), 64'd0);
        check("rs_d3", d3_o, 64'd0);
        #2 rst = 1'b0;
        drive(1'b1, 2'b01, 64'hABCD, 5'd10);
        step();
        drive(1'b0, 2'b00, 64'd0, 5'd0);
        check("rs_lat_e0", 64'(v3_o), 64'd0);
        step();
        check("rs_lat_e1", 64'(v3_o), 64'd0);
        step();
        check("rs_lat_e2_v", 64'(v3_o), 64'd1);
        check("rs_lat_e2_rd", 64'(r3_o), 64'd10);
        check("rs_lat_e2_d", d3_o, 64'hABCD);

        // rd=x0 capture
        drive(1'b1, 2'b11, 64'h77, 5'd0);
        step();
        drive(1'b0, 2'b00, 64'd0, 5'd0);
        step();
        check("x0_v", 64'(v2_o), 64'd1);
`ifdef PIPE_STAGE_RD0_SQUASH_EN
        check("x0_c", 64'(c2_o), 64'd2);
        check("x0_we", 64'(we2_o), 64'd0);
`else
        check("x0_c", 64'(c2_o), 64'd3);
        check("x0_we", 64'(we2_o), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register for the 5-stage core. It generalises the fixed EX/MEM and MEM/WB latches to a configurable depth, payload width, channel count and control width.
- Adds a valid bit, stall (hold), flush (bubble insertion) and per-stage forwarding taps for the hazard/forwarding unit.
- Instantiated between any two stages; STAGES>1 is used for retimed multi-cycle paths.

Parameters:
- STAGES, 1, number of register stages in the chain (>=1).
- NUM_DATA, 2, number of data channels (e.g. mem data and ALU result).
- DATA_W, 32, width of each data channel.
- CTRL_W, 2, width of the control bundle.
- RD_W, 5, destination register address width.
- WE_BIT, 0, index within the control bundle of the RegWrite bit.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold every stage.
- flush_i  in  1  invalidate every stage (bubble).
- valid_i  in  1  incoming instruction valid.
- ctrl_i  in  CTRL_W  control bundle (RegWrite, MemtoReg, ...).
- data_i  in  NUM_DATA*DATA_W  packed data channels; channel k is bits [k*DATA_W +: DATA_W].
- rd_addr_i  in  RD_W  destination register.
- valid_o  out  1  last-stage valid.
- ctrl_o  out  CTRL_W  last-stage control.
- data_o  out  NUM_DATA*DATA_W  last-stage data.
- rd_addr_o  out  RD_W  last-stage destination.
- fwd_we_o  out  STAGES  per-stage effective RegWrite; bit s = stage s, where stage 0 is nearest the input.
- fwd_rd_o  out  STAGES*RD_W  per-stage rd address, same indexing.

Behaviour:
- Reset: while rst_i=1, asynchronously clear every stage's valid, ctrl, data and rd to 0. All outputs read 0. Applies mid-operation with no clock edge required.
- Capture value at stage 0: valid <= valid_i; ctrl <= valid_i ? ctrl_i : 0; data <= data_i; rd <= rd_addr_i.
- Stage s>0 captures stage s-1 unchanged.
- Invariant: a stage with valid=0 always holds ctrl=0.
- Priority at each rising edge, highest first:
  1. flush_i=1: every stage loads valid=0, ctrl=0, data=0, rd=0. This wins over stall_i and over valid_i.
  2. stall_i=1: every stage holds its current contents, including invalid stages. valid_i is ignored and the input instruction is not captured; upstream must also hold.
  3. Otherwise: the whole chain shifts by one.
- Latency: STAGES cycles from input to valid_o, with no stalls or flushes. Throughput is 1 per cycle.
- Outputs: valid_o, ctrl_o, data_o and rd_addr_o come directly from last-stage registers. No combinational path from any input.
- fwd_we_o[s] = stage s valid AND ctrl[WE_BIT] (subject to the optional feature below). fwd_rd_o slice s = stage s rd. These are combinational from registers only.
- No partial stall: the chain either moves as a whole or is frozen.
- Widths: no arithmetic is performed. Data is carried bit-exact across all NUM_DATA channels.

Optional Feature:
- Macro: PIPE_STAGE_RD0_SQUASH_EN.
- Defined: at stage-0 capture, if rd_addr_i==0, the WE_BIT of the captured ctrl is forced to 0. Other ctrl bits, data and valid are unaffected. Consequently ctrl_o[WE_BIT] and fwd_we_o never assert for rd=0, so writes to x0 are never forwarded.
- Undefined: ctrl is captured exactly as specified above with no rd-dependent masking. x0 protection is left to the register file.

Test Plan:
- Reset mid-stream: STAGES=3, stream 3 valid instrs, then assert rst_i between edges -> all outputs 0 immediately. After release, valid_o=0 until new input has travelled 3 cycles.
- Pipeline latency: STAGES=2, valid_i=1, ctrl_i=2'b11, data_i={32'hDEADBEEF,32'h00000004}, rd_addr_i=5'd7 at edge 0 -> same values on outputs after edge 1; fwd_we_o=2'b01 after edge 0 and 2'b10 after edge 1.
- Invalid input: valid_i=0, ctrl_i=2'b11 -> captured ctrl=0 and fwd_we_o bit 0 = 0.
- Stall: STAGES=2, stall_i=1 for 3 cycles with a new input changing every cycle -> outputs and fwd taps frozen. After release, the chain shifts exactly one position per cycle and the stalled inputs are never captured.
- Flush+stall same edge: valid data in both stages, flush_i=1 and stall_i=1 -> next cycle valid_o=0, ctrl_o=0, fwd_we_o=0, data_o=0.
- Feature: with PIPE_STAGE_RD0_SQUASH_EN defined, valid_i=1, ctrl_i=2'b11, rd_addr_i=0 -> ctrl_o=2'b10 and valid_o=1. Without the macro, ctrl_o=2'b11.
